// File: rtl/main_ctrl.sv
// Sequencing FSM for the y/s datapath of `main`: single-cycle load, popcount scan
// and set-bit enumeration, with strobes decoded from state, regime and b.
module main_ctrl #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = 3,
    parameter int COUNT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       on,
    input  logic             start,
    input  logic             b,
    output logic [1:0]       regime,
    output logic             active,
    output logic [1:0]       y_select_next,
    output logic             y_en,
    output logic             y_store_x,
    output logic             s_en,
    output logic             s_add,
    output logic             s_zero,
    output logic [1:0]       s_step,
    output logic [IDX_W-1:0] idx,
    output logic             hit,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_ARMED, S_RUN, S_DONE} state_t;

    localparam logic [1:0] REG_OFF    = 2'd0;
    localparam logic [1:0] REG_ENUM   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_UPDATE = 2'd3;

    state_t           r_state, w_next;
    logic [1:0]       r_regime, w_regime_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [IDX_W-1:0] r_s, w_s_next;
    logic             r_ovf, w_ovf_next;
    logic             r_first, w_first_next;
    logic [IDX_W:0]   w_sum;

    // Shadow of the datapath s counter, so COUNT can detect a wrap locally.
    assign w_sum = {1'b0, r_s} + (IDX_W+1)'(COUNT_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_regime <= REG_OFF;
            r_idx    <= '0;
            r_s      <= '0;
            r_ovf    <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_regime <= w_regime_next;
            r_idx    <= w_idx_next;
            r_s      <= w_s_next;
            r_ovf    <= w_ovf_next;
            r_first  <= w_first_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_regime_next = r_regime;
        w_idx_next    = r_idx;
        w_ovf_next    = r_ovf;
        w_first_next  = 1'b0;
        active        = 1'b0;
        y_select_next = 2'b00;
        y_en          = 1'b0;
        y_store_x     = 1'b0;
        s_en          = 1'b0;
        s_add         = 1'b0;
        s_zero        = 1'b0;
        s_step        = 2'd0;
        hit           = 1'b0;
        done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (on == REG_UPDATE) begin
                    w_regime_next = REG_UPDATE;
                    w_next        = S_UPDATE;
                end else if (on != REG_OFF) begin
                    w_regime_next = on;
                    w_next        = S_ARMED;
                end
            end
            S_UPDATE: begin
                active        = 1'b1;
                y_select_next = 2'b10;
                y_store_x     = 1'b1;
                y_en          = 1'b1;
                s_en          = 1'b1;
                s_zero        = 1'b1;
                w_regime_next = REG_OFF;
                w_next        = S_IDLE;
            end
            S_ARMED: begin
                if (start) begin
                    s_en       = 1'b1;
                    s_zero     = 1'b1;
                    w_ovf_next = 1'b0;
                    w_idx_next = '0;
                    w_next     = S_RUN;
                end
            end
            S_RUN: begin
                active        = 1'b1;
                y_select_next = 2'b01;
                y_en          = 1'b1;
                if (r_regime == REG_COUNT) begin
                    s_en   = b;
                    s_add  = b;
                    s_step = 2'(COUNT_STEP);
                    if (b && w_sum[IDX_W])
                        w_ovf_next = 1'b1;
                end else if (r_regime == REG_ENUM) begin
                    hit    = b;
                    s_en   = b;
                    s_add  = b;
                    s_step = 2'd1;
                end
                if (r_idx == IDX_W'(WIDTH-1)) begin
                    w_idx_next   = '0;
                    w_first_next = 1'b1;
                    w_next       = S_DONE;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                // A held start parks here so it cannot relaunch another scan.
                done = r_first;
                if (!start) begin
                    w_regime_next = REG_OFF;
                    w_next        = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_s_next = r_s;
        if (s_en) begin
            if (s_zero)
                w_s_next = '0;
            else if (s_add)
                w_s_next = r_s + IDX_W'(s_step);
        end
    end

    assign regime = r_regime;
    assign idx    = r_idx;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_main_ctrl.sv
// Directed bench for main_ctrl with a small model of the y/s datapath of `main`.
module tb_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] on;
    logic       start;
    logic       b;
    logic [1:0] regime;
    logic       active;
    logic [1:0] y_select_next;
    logic       y_en, y_store_x, s_en, s_add, s_zero;
    logic [1:0] s_step;
    logic [2:0] idx;
    logic       hit, ovf, done;

    logic [7:0] x_m;
    logic [7:0] y_m = 8'd0;
    logic [2:0] s_m = 3'd0;
    int         n_tot = 0;
    int         n_bad = 0;

    main_ctrl #(.WIDTH(8), .IDX_W(3), .COUNT_STEP(1)) dut (
        .clk(clk), .rst(rst), .on(on), .start(start), .b(b),
        .regime(regime), .active(active), .y_select_next(y_select_next),
        .y_en(y_en), .y_store_x(y_store_x), .s_en(s_en), .s_add(s_add),
        .s_zero(s_zero), .s_step(s_step), .idx(idx), .hit(hit),
        .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    assign b = y_m[0];

    always @(posedge clk) begin
        if (y_en) begin
            case (y_select_next)
                2'b01:   y_m <= {y_m[0], y_m[7:1]};
                2'b10:   y_m <= x_m;
                2'b11:   y_m <= 8'd0;
                default: y_m <= y_m;
            endcase
        end
        if (s_en) begin
            if (s_zero)     s_m <= 3'd0;
            else if (s_add) s_m <= s_m + 3'(s_step);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_update(input logic [7:0] v);
        x_m = v;
        @(negedge clk); on = 2'd3;
        @(negedge clk); on = 2'd0; #1;
        chk("upd_store_x", y_store_x, 1);
        chk("upd_sel", y_select_next, 2);
        chk("upd_yen", y_en, 1);
        chk("upd_szero", s_zero & s_en, 1);
        chk("upd_active", active, 1);
        @(negedge clk); #1;
        chk("upd_regime_after", regime, 0);
        chk("upd_active_after", active, 0);
        chk("upd_y", y_m, v);
        chk("upd_s", s_m, 0);
    endtask

    task automatic launch(input logic [1:0] r);
        @(negedge clk); on = r;
        @(negedge clk); on = 2'd0; start = 1'b1; #1;
        chk("arm_regime", regime, r);
        chk("arm_active", active, 0);
        chk("arm_szero", s_zero & s_en, 1);
        @(negedge clk);
    endtask

    task automatic run_scan(input logic [1:0] r, input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("run_idx", idx, i);
            chk("run_active", active, 1);
            chk("run_rot", {y_en, y_select_next}, 3'b101);
            chk("run_no_store", y_store_x, 0);
            chk("run_regime", regime, r);
            if (r == 2'd2) begin
                chk("cnt_s_add", s_add, pat[i]);
                chk("cnt_hit", hit, 0);
            end else begin
                chk("enum_hit", hit, pat[i]);
                chk("enum_s_add", s_add, pat[i]);
            end
            chk("run_done", done, 0);
        end
    endtask

    task automatic finish_done(input logic [1:0] r, input logic [2:0] s_exp,
                               input logic ovf_exp, input logic [7:0] y_exp);
        @(negedge clk); #1;
        chk("done_pulse", done, 1);
        chk("done_active", active, 0);
        chk("done_s", s_m, s_exp);
        chk("done_ovf", ovf, ovf_exp);
        chk("done_y", y_m, y_exp);
        @(negedge clk); #1;
        chk("done_held", done, 0);
        chk("done_held_regime", regime, r);
        start = 1'b0;
        @(negedge clk); #1;
        chk("idle_regime", regime, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; on = 2'd0; start = 1'b0; x_m = 8'd0;
        #1;
        chk("rst_regime", regime, 0);
        chk("rst_active", active, 0);
        chk("rst_idx", idx, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_strobes", {y_en, s_en, hit, done}, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;

        // UPDATE then COUNT on 0b00111001
        do_update(8'd57);
        launch(2'd2);
        run_scan(2'd2, 8'b0011_1001);
        finish_done(2'd2, 3'd4, 1'b0, 8'd57);

        // COUNT wrap: eight ones overflow a 3-bit counter
        do_update(8'hFF);
        launch(2'd2);
        run_scan(2'd2, 8'hFF);
        finish_done(2'd2, 3'd0, 1'b1, 8'hFF);
        chk("ovf_sticky", ovf, 1);
        do_update(8'h01);
        launch(2'd2);
        run_scan(2'd2, 8'h01);
        finish_done(2'd2, 3'd1, 1'b0, 8'h01);

        // ENUM with on changed to UPDATE mid-scan
        do_update(8'd57);
        launch(2'd1);
        on = 2'd3;
        run_scan(2'd1, 8'b0011_1001);
        on = 2'd0;
        finish_done(2'd1, 3'd4, 1'b0, 8'd57);

        // start held in IDLE with on=0 does nothing
        start = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_start_active", active, 0);
            chk("idle_start_yen", y_en, 0);
            chk("idle_start_regime", regime, 0);
        end
        start = 1'b0;

        // async reset at idx=4 of a COUNT scan
        launch(2'd2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
        end
        chk("pre_rst_idx", idx, 4);
        rst = 1'b1; #1;
        chk("midrst_active", active, 0);
        chk("midrst_yen", y_en, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_regime", regime, 0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0; on = 2'd2;
        @(negedge clk); on = 2'd0; #1;
        chk("postrst_regime", regime, 2);
        chk("postrst_active", active, 0);
        @(negedge clk); #1;
        chk("postrst_no_resume", {active, y_en}, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/main_ctrl.md
Name: main_ctrl

Overview:
Control FSM that sequences the 8-bit y register / 3-bit s counter datapath of `main`. Latches the requested regime from `on`, waits for `start`, then drives the per-cycle datapath strobes (y_select_next, y_en, y_store_x, s_en, s_add, s_zero, s_step). Supported operations: single-cycle update, 8-cycle popcount scan and 8-cycle set-bit enumeration. Consumes the datapath status bit `b`, defined as y[0] of the current y value.

Parameters:
WIDTH, 8, width of y; sets the scan length of one RUN.
IDX_W, 3, width of the bit index and of the s counter; must equal clog2(WIDTH).
COUNT_STEP, 1, value driven on s_step during COUNT (range 1..3).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
on  input  2  regime request: 0 OFF, 1 ENUM, 2 COUNT, 3 UPDATE
start  input  1  level start; a rising-edge sample (start=1 while ARMED) launches RUN
b  input  1  datapath status, y[0]
regime  output  2  latched regime, 0 when idle
active  output  1  high in UPDATE and RUN states
y_select_next  output  2  y mux: 00 hold, 01 rotate right by 1, 10 load x, 11 clear
y_en  output  1  y register write enable
y_store_x  output  1  high exactly when y_select_next=10
s_en  output  1  s register write enable
s_add  output  1  with s_en: s <= s + s_step (mod 2^IDX_W)
s_zero  output  1  with s_en: s <= 0; has priority over s_add
s_step  output  2  increment amount
idx  output  IDX_W  bit position currently presented on b during RUN, else 0
hit  output  1  ENUM only: pulse in the cycle b=1; idx is that bit's position
ovf  output  1  COUNT only: sticky until next launch; set if the count wrapped past 2^IDX_W-1
done  output  1  one-cycle pulse on the cycle entering DONE

Behaviour:
- States: IDLE, UPDATE, ARMED, RUN, DONE. Reset (async, any time, including mid-RUN): state=IDLE, idx=0, regime=0, ovf=0, and all strobes, active, hit and done=0.
- All strobe outputs are decoded from the current state/regime/b (Moore plus b). Unlisted strobes are 0 in every state.
- IDLE: `on` is sampled only here.
  - on=0: stay in IDLE.
  - on=3: regime<=3, go to UPDATE.
  - on=1 or 2: regime<=on, go to ARMED.
  - start is ignored in IDLE.
- UPDATE (exactly 1 cycle): y_select_next=10, y_store_x=1, y_en=1, s_en=1, s_zero=1, active=1. Next state is IDLE with regime<=0.
- ARMED: active=0; regime is held, and `on` changes are ignored.
  - start=1: go to RUN; that same cycle drive s_en=1, s_zero=1, clear ovf, idx<=0.
  - start=0: stay in ARMED indefinitely. Only rst leaves ARMED otherwise.
- RUN: lasts exactly WIDTH cycles, with idx = 0..WIDTH-1. Each cycle: active=1, y_select_next=01, y_en=1. After WIDTH rotations y equals its value before RUN.
  - COUNT: s_en=b, s_add=b, s_step=COUNT_STEP. If b=1 and s+COUNT_STEP > 2^IDX_W-1, set ovf (s still wraps).
  - ENUM: hit=b. s_en=b, s_add=b, s_step=1, so s counts the hits.
- End of RUN: on the cycle with idx=WIDTH-1, next state is DONE and idx<=0.
- DONE: done=1 for the entry cycle only, active=0.
  - If start is still 1, remain in DONE (done=0 after the first cycle) until start=0. This prevents a held start from re-triggering.
  - Then go to IDLE with regime<=0.
- Mid-operation: `on` and `start` changes in UPDATE/RUN are ignored. b is ignored outside RUN.

Test Plan:
- Reset mid-RUN: assert rst at RUN idx=4 -> all outputs 0 in the same cycle (async), state IDLE. After release, on=2 -> ARMED; RUN is not resumed.
- UPDATE: x=57, on=3 for 1 cycle from IDLE -> one cycle of y_store_x=1, y_en=1, s_zero=1, active=1, then regime=0. Datapath y=57, s=0.
- COUNT: y=57 (0b00111001), on=2, start=1 held 10 cycles -> 8 RUN cycles with s_add pattern 1,0,0,1,1,1,0,0. Final s=4, ovf=0, y=57. done pulses once; IDLE is reached only after start drops.
- COUNT overflow: y=0xFF, COUNT_STEP=1 -> s=0 after RUN, ovf=1. Then y=0x01 with a new launch -> ovf=0, s=1.
- ENUM: y=57, on=1, start=1 -> hit pulses with idx=0,3,4,5, final s=4, done=1 on the 9th cycle after start is sampled.
- Held/ignored inputs: start=1 while IDLE with on=0 -> no activity. on toggled 1->3 during RUN -> regime stays 1 and no y_store_x occurs.
